// File: rtl/motor_ramp_ctrl_pkg.sv
// Shared constants, FSM encoding and small helpers for the motor speed-ramp sequencer.
package motor_ramp_ctrl_pkg;

  localparam int MOTOR_PWM_RES    = 8;
  localparam int MOTOR_NBITS      = MOTOR_PWM_RES + 1;
  localparam int MOTOR_RAMP_STEP  = 4;
  localparam int MOTOR_TICK_DIV   = 1000;
  localparam int MOTOR_DEAD_TICKS = 10;
  localparam int MOTOR_WDOG_TICKS = 500;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DEAD = 2'd2
  } state_e;

  // A nonzero target whose sign differs from the last driven direction needs a stop at zero.
  function automatic logic is_reversal(input logic tgt_nz, input logic tgt_neg, input logic dir_neg);
    return tgt_nz && (tgt_neg != dir_neg);
  endfunction

endpackage

// File: rtl/motor_ramp_ctrl_if.sv
// Set-point handshake bundle between the host and the ramp sequencer.
interface motor_ramp_ctrl_if #(
  parameter int NBITS = 9
);

  logic                    cmd_valid;
  logic                    cmd_ready;
  logic signed [NBITS-1:0] cmd_speed;

  modport master (
    output cmd_valid,
    output cmd_speed,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_speed,
    output cmd_ready
  );

endinterface

// File: rtl/motor_ramp_ctrl_tick_gen.sv
// Free-running divider producing a one-cycle tick every TICK_DIV enabled clocks.
module motor_ramp_ctrl_tick_gen #(
  parameter int TICK_DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_r;

  // Divider counter, held at zero while disabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= '0;
    end else if (!en) begin
      cnt_r <= '0;
    end else if (cnt_r == LAST) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  assign tick = en && (cnt_r == LAST);

endmodule

// File: rtl/motor_ramp_ctrl.sv
// Slews a signed PWM command toward host set-points at a bounded rate, with a
// zero-speed dead time on every direction reversal and a command watchdog.
module motor_ramp_ctrl
  import motor_ramp_ctrl_pkg::*;
#(
  parameter int NBITS      = MOTOR_NBITS,
  parameter int STEP       = MOTOR_RAMP_STEP,
  parameter int TICK_DIV   = MOTOR_TICK_DIV,
  parameter int DEAD_TICKS = MOTOR_DEAD_TICKS,
  parameter int WDOG_TICKS = MOTOR_WDOG_TICKS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en_i,
  motor_ramp_ctrl_if.slave        cmd,
  output logic signed [NBITS-1:0] pwm_o,
  output logic                    drv_en_o,
  output logic                    busy_o,
  output logic                    timeout_o
);

  localparam int DW = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS + 1) : 1;
  localparam int WW = (WDOG_TICKS > 1) ? $clog2(WDOG_TICKS + 1) : 1;

  localparam logic [DW-1:0]           DEAD_LAST = DW'(DEAD_TICKS - 1);
  localparam logic [WW-1:0]           WDOG_LAST = WW'(WDOG_TICKS - 1);
  localparam logic signed [NBITS-1:0] ZERO      = '0;
  localparam logic signed [NBITS-1:0] MOST_NEG  = {1'b1, {(NBITS-1){1'b0}}};
  localparam logic signed [NBITS-1:0] NEG_LIM   = {1'b1, {(NBITS-2){1'b0}}, 1'b1};
  localparam logic signed [NBITS:0]   STEP_W    = (NBITS+1)'(STEP);
  localparam logic [NBITS-1:0]        STEP_N    = NBITS'(STEP);

  // The driver negates the command to get a magnitude, which overflows on the most negative code.
  function automatic logic signed [NBITS-1:0] clamp_cmd(input logic signed [NBITS-1:0] v);
    if (v == MOST_NEG) begin
      return NEG_LIM;
    end else begin
      return v;
    end
  endfunction

  state_e                  state_r, state_n;
  logic signed [NBITS-1:0] pwm_r, pwm_n;
  logic signed [NBITS-1:0] target_r, target_n;
  logic signed [NBITS-1:0] pend_r, pend_n;
  logic                    pend_vld_r, pend_vld_n;
  logic                    dir_neg_r, dir_neg_n;
  logic [DW-1:0]           dead_r, dead_n;
  logic [WW-1:0]           wdog_r, wdog_n;
  logic                    timeout_r, timeout_n;
  logic                    drv_en_r, drv_en_n;
  logic                    busy_r, busy_n;

  logic                    tick_s;
  logic                    accept_s;
  logic signed [NBITS-1:0] cmd_clamp_s;
  logic signed [NBITS-1:0] goal_s;
  logic signed [NBITS:0]   diff_s;
  logic signed [NBITS:0]   mag_s;
  logic [NBITS-1:0]        stp_s;
  logic signed [NBITS-1:0] ramp_s;

  motor_ramp_ctrl_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (en_i),
    .tick (tick_s)
  );

  assign cmd.cmd_ready = en_i && rst;
  assign accept_s      = cmd.cmd_valid && en_i && rst;
  assign cmd_clamp_s   = clamp_cmd(cmd.cmd_speed);

  // One ramp step toward the goal; opposite-signed target first aims at zero.
  always_comb begin
    goal_s = target_r;
    if ((pwm_r != ZERO) && (target_r != ZERO) && (pwm_r[NBITS-1] != target_r[NBITS-1])) begin
      goal_s = ZERO;
    end else begin
      goal_s = target_r;
    end
    diff_s = {goal_s[NBITS-1], goal_s} - {pwm_r[NBITS-1], pwm_r};
    if (diff_s[NBITS]) begin
      mag_s = -diff_s;
    end else begin
      mag_s = diff_s;
    end
    if (mag_s > STEP_W) begin
      stp_s = STEP_N;
    end else begin
      stp_s = mag_s[NBITS-1:0];
    end
    if (diff_s[NBITS]) begin
      ramp_s = pwm_r - stp_s;
    end else begin
      ramp_s = pwm_r + stp_s;
    end
  end

  // Next-state logic: command capture, watchdog, and the IDLE/RUN/DEAD sequencer.
  always_comb begin
    state_n    = state_r;
    pwm_n      = pwm_r;
    target_n   = target_r;
    pend_n     = pend_r;
    pend_vld_n = 1'b0;
    dir_neg_n  = dir_neg_r;
    dead_n     = dead_r;
    wdog_n     = wdog_r;
    timeout_n  = timeout_r;
    drv_en_n   = drv_en_r;

    if (!en_i) begin
      state_n   = ST_IDLE;
      pwm_n     = ZERO;
      target_n  = ZERO;
      pend_n    = ZERO;
      dead_n    = '0;
      wdog_n    = '0;
      timeout_n = 1'b0;
      drv_en_n  = 1'b0;
    end else begin
      // Accepted set-points land in target one cycle later, so a same-edge tick ramps on the old one.
      if (pend_vld_r) begin
        target_n = pend_r;
      end else begin
        target_n = target_r;
      end

      if (accept_s) begin
        pend_n     = cmd_clamp_s;
        pend_vld_n = 1'b1;
        wdog_n     = '0;
        timeout_n  = 1'b0;
      end else if (tick_s && (state_r != ST_IDLE)) begin
        if (wdog_r == WDOG_LAST) begin
          wdog_n = '0;
          if (!pend_vld_r) begin
            target_n  = ZERO;
            timeout_n = 1'b1;
          end else begin
            timeout_n = timeout_r;
          end
        end else begin
          wdog_n = wdog_r + WW'(1);
        end
      end else begin
        wdog_n = wdog_r;
      end

      case (state_r)
        ST_IDLE: begin
          state_n  = ST_RUN;
          drv_en_n = 1'b1;
        end
        ST_RUN: begin
          if (tick_s) begin
            pwm_n = ramp_s;
            if (ramp_s != ZERO) begin
              dir_neg_n = ramp_s[NBITS-1];
            end else if (is_reversal(target_r != ZERO, target_r[NBITS-1], dir_neg_r)) begin
              state_n = ST_DEAD;
              dead_n  = '0;
            end else begin
              state_n = ST_RUN;
            end
          end else begin
            pwm_n = pwm_r;
          end
        end
        ST_DEAD: begin
          pwm_n = ZERO;
          if (accept_s && !is_reversal(cmd_clamp_s != ZERO, cmd_clamp_s[NBITS-1], dir_neg_r)) begin
            state_n = ST_RUN;
            dead_n  = '0;
          end else if (tick_s) begin
            if (dead_r == DEAD_LAST) begin
              state_n = ST_RUN;
              dead_n  = '0;
            end else begin
              dead_n = dead_r + DW'(1);
            end
          end else begin
            dead_n = dead_r;
          end
        end
        default: begin
          state_n  = ST_IDLE;
          pwm_n    = ZERO;
          drv_en_n = 1'b0;
        end
      endcase
    end

    busy_n = (pwm_n != target_n) || (state_n == ST_DEAD);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      pwm_r      <= '0;
      target_r   <= '0;
      pend_r     <= '0;
      pend_vld_r <= 1'b0;
      dir_neg_r  <= 1'b0;
      dead_r     <= '0;
      wdog_r     <= '0;
      timeout_r  <= 1'b0;
      drv_en_r   <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_n;
      pwm_r      <= pwm_n;
      target_r   <= target_n;
      pend_r     <= pend_n;
      pend_vld_r <= pend_vld_n;
      dir_neg_r  <= dir_neg_n;
      dead_r     <= dead_n;
      wdog_r     <= wdog_n;
      timeout_r  <= timeout_n;
      drv_en_r   <= drv_en_n;
      busy_r     <= busy_n;
    end
  end

  assign pwm_o     = pwm_r;
  assign drv_en_o  = drv_en_r;
  assign busy_o    = busy_r;
  assign timeout_o = timeout_r;

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Directed bench for motor_ramp_ctrl: ramp, reversal dead time, clamp, watchdog, stop and reset.
module tb_motor_ramp_ctrl;

  localparam int NB = 9;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 en_i = 1'b0;
  logic signed [NB-1:0] pwm_o;
  logic                 drv_en_o;
  logic                 busy_o;
  logic                 timeout_o;

  int total = 0;
  int bad   = 0;

  // Reference tick: the last rising edge was a ramp tick (TICK_DIV = 4).
  logic [1:0] m_cnt;
  logic       m_tick;

  motor_ramp_ctrl_if #(.NBITS(NB)) cmd_if ();

  motor_ramp_ctrl #(
    .NBITS      (NB),
    .STEP       (4),
    .TICK_DIV   (4),
    .DEAD_TICKS (2),
    .WDOG_TICKS (50)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en_i      (en_i),
    .cmd       (cmd_if),
    .pwm_o     (pwm_o),
    .drv_en_o  (drv_en_o),
    .busy_o    (busy_o),
    .timeout_o (timeout_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cnt  <= 2'd0;
      m_tick <= 1'b0;
    end else if (!en_i) begin
      m_cnt  <= 2'd0;
      m_tick <= 1'b0;
    end else begin
      m_tick <= (m_cnt == 2'd3);
      m_cnt  <= m_cnt + 2'd1;
    end
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic next_tick();
    int g;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!m_tick && (g < 12));
    if (!m_tick) begin
      total++;
      bad++;
      $error("FAIL tick_wait observed=no_tick expected=tick");
    end
  endtask

  task automatic send(input int v);
    cmd_if.cmd_speed = NB'(v);
    cmd_if.cmd_valid = 1'b1;
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=hang expected=finish");
    $fatal(1);
  end

  initial begin
    logic saw_min;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_speed = '0;
    rst  = 1'b0;
    en_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pwm", pwm_o, 0);
    chk("rst_drv", drv_en_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_tmo", timeout_o, 0);
    chk("rst_ready", cmd_if.cmd_ready, 0);
    rst = 1'b1;
    #1 chk("ready_en_low", cmd_if.cmd_ready, 0);

    // 1: accept +10 from standstill
    @(negedge clk);
    en_i = 1'b1;
    #1 chk("ready_en_high", cmd_if.cmd_ready, 1);
    send(10);
    chk("t1_drv", drv_en_o, 1);
    @(negedge clk);
    chk("t1_busy_set", busy_o, 1);
    next_tick(); chk("t1_p4", pwm_o, 4);
    next_tick(); chk("t1_p8", pwm_o, 8);
    next_tick(); chk("t1_p10", pwm_o, 10);
    chk("t1_busy_clr", busy_o, 0);

    // 2: reversal to -6 through a two-tick dead time
    send(-6);
    next_tick(); chk("t2_p6", pwm_o, 6);
    next_tick(); chk("t2_p2", pwm_o, 2);
    next_tick(); chk("t2_p0", pwm_o, 0);
    chk("t2_dead_busy", busy_o, 1);
    next_tick(); chk("t2_dead1", pwm_o, 0);
    next_tick(); chk("t2_dead2", pwm_o, 0);
    next_tick(); chk("t2_m4", pwm_o, -4);
    next_tick(); chk("t2_m6", pwm_o, -6);
    chk("t2_busy_clr", busy_o, 0);

    // 3: most negative command clamps to -255
    saw_min = 1'b0;
    send(-256);
    for (int k = 1; k <= 66; k++) begin
      next_tick();
      if (pwm_o == -9'sd256) saw_min = 1'b1;
      if (k == 1)  chk("t3_k1", pwm_o, -10);
      if (k == 62) chk("t3_k62", pwm_o, -254);
      if (k == 63) chk("t3_k63", pwm_o, -255);
      if (k == 30) send(-256);
    end
    chk("t3_final", pwm_o, -255);
    chk("t3_no_min", saw_min, 0);
    chk("t3_busy", busy_o, 0);
    chk("t3_tmo", timeout_o, 0);

    // 4: watchdog expiry at +40 and recovery
    en_i = 1'b0;
    @(negedge clk);
    chk("t4_stop", pwm_o, 0);
    en_i = 1'b1;
    send(40);
    for (int k = 1; k <= 60; k++) begin
      next_tick();
      if (k == 10) chk("t4_p40", pwm_o, 40);
      if (k == 49) begin
        chk("t4_tmo_pre", timeout_o, 0);
        chk("t4_p40_hold", pwm_o, 40);
      end
      if (k == 50) begin
        chk("t4_tmo_set", timeout_o, 1);
        chk("t4_p40_exp", pwm_o, 40);
        chk("t4_busy_exp", busy_o, 1);
      end
      if (k == 51) chk("t4_p36", pwm_o, 36);
    end
    chk("t4_p0", pwm_o, 0);
    chk("t4_tmo_sticky", timeout_o, 1);
    send(8);
    chk("t4_tmo_clr", timeout_o, 0);
    next_tick(); chk("t4_up4", pwm_o, 4);
    next_tick(); chk("t4_up8", pwm_o, 8);

    // 5: emergency stop mid-ramp
    send(100);
    next_tick(); chk("t5_p12", pwm_o, 12);
    next_tick(); chk("t5_p16", pwm_o, 16);
    next_tick(); chk("t5_p20", pwm_o, 20);
    en_i = 1'b0;
    #1 chk("t5_ready_off", cmd_if.cmd_ready, 0);
    @(negedge clk);
    chk("t5_pwm_off", pwm_o, 0);
    chk("t5_drv_off", drv_en_o, 0);
    chk("t5_busy_off", busy_o, 0);
    en_i = 1'b1;
    @(negedge clk);
    chk("t5_drv_on", drv_en_o, 1);
    next_tick();
    next_tick(); chk("t5_hold0", pwm_o, 0);
    chk("t5_busy_idle", busy_o, 0);

    // 6: asynchronous reset while in the dead time
    send(12);
    next_tick();
    next_tick();
    next_tick(); chk("t6_p12", pwm_o, 12);
    send(-8);
    next_tick();
    next_tick();
    next_tick(); chk("t6_p0", pwm_o, 0);
    chk("t6_dead_busy", busy_o, 1);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_pwm", pwm_o, 0);
    chk("t6_rst_drv", drv_en_o, 0);
    chk("t6_rst_busy", busy_o, 0);
    chk("t6_rst_tmo", timeout_o, 0);
    chk("t6_rst_ready", cmd_if.cmd_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    send(8);
    chk("t6_drv_on", drv_en_o, 1);
    next_tick(); chk("t6_p4", pwm_o, 4);
    next_tick(); chk("t6_p8", pwm_o, 8);
    chk("t6_busy_clr", busy_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
